// File: rtl/rf_bank_stack.sv
// Priority-banked register file with per-level banks, shared registers and
// hardware argument passing from the preempted bank on interrupt entry.
module rf_bank_stack #(
   parameter int unsigned          DataWidth  = 32,
   parameter int unsigned          RegNum     = 32,
   parameter int unsigned          PrioNum    = 8,
   parameter logic [31:0]          SharedMask = 32'h0000_0004,
   parameter int unsigned          RaAddr     = 1,
   parameter logic [DataWidth-1:0] RaMagic    = {DataWidth{1'b1}},
   parameter int unsigned          ArgBase    = 10,
   parameter int unsigned          ArgNum     = 2,
   localparam int unsigned         LevelW     = (PrioNum > 1) ? $clog2(PrioNum) : 1,
   localparam int unsigned         AddrW      = (RegNum > 1) ? $clog2(RegNum) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [LevelW-1:0]    level,
   input  logic                 writeEn,
   input  logic [AddrW-1:0]     writeAddr,
   input  logic [DataWidth-1:0] writeData,
   input  logic [AddrW-1:0]     readAddr1,
   input  logic [AddrW-1:0]     readAddr2,
   output logic [DataWidth-1:0] readData1,
   output logic [DataWidth-1:0] readData2,
   input  logic                 entryEn,
   input  logic [LevelW-1:0]    entryFrom,
   output logic                 busy,
   output logic                 entryErr
);

   localparam int unsigned         IdxW      = (ArgNum > 1) ? $clog2(ArgNum) : 1;
   localparam logic [RegNum-1:0]   SharedVec = SharedMask[RegNum-1:0];
   localparam logic [AddrW-1:0]    AddrZero  = {AddrW{1'b0}};
   localparam logic [AddrW-1:0]    RaIdx     = AddrW'(RaAddr);
   localparam logic                RaOk      = (RaAddr != 0) && (RaAddr < RegNum);
   localparam logic [IdxW-1:0]     IdxLast   = IdxW'((ArgNum == 0) ? 0 : ArgNum - 1);
   localparam logic [DataWidth-1:0] DataZero = {DataWidth{1'b0}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      COPY = 1'b1
   } state_e;

   // Shared registers live in the bank-0 slot; their other bank slots are never used.
   logic [DataWidth-1:0] regs_q [PrioNum][RegNum];
   logic [DataWidth-1:0] regs_d [PrioNum][RegNum];

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [LevelW-1:0]   from_q, from_d;
   logic [LevelW-1:0]   to_q, to_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                level_ok_s;
   logic                copy_ok_s;
   logic [31:0]         cp_reg_s;
   logic [AddrW-1:0]    cp_addr_s;

   function automatic logic addr_ok(input logic [AddrW-1:0] a);
      return (a != AddrZero) && (32'(a) < RegNum);
   endfunction

   function automatic logic [DataWidth-1:0] read_port(input logic [AddrW-1:0] a);
      logic [DataWidth-1:0] v;
      if (!level_ok_s || !addr_ok(a)) begin
         v = DataZero;
      end else if (SharedVec[a]) begin
         v = regs_q[0][a];
      end else begin
         v = regs_q[level][a];
      end
      return v;
   endfunction

   // Qualifiers for the current level and the current copy slot.
   always_comb begin
      level_ok_s = (32'(level) < PrioNum);
      cp_reg_s   = ArgBase + 32'(idx_q);
      cp_addr_s  = cp_reg_s[AddrW-1:0];
      copy_ok_s  = (cp_reg_s < RegNum) && (cp_addr_s != AddrZero) && !SharedVec[cp_addr_s]
                   && (32'(to_q) < PrioNum) && (32'(from_q) < PrioNum);
   end

   // Combinational read ports; no bypass from the write port.
   always_comb begin
      readData1 = read_port(readAddr1);
      readData2 = read_port(readAddr2);
   end

   // Next-state: core write, entry handling (ra load wins) and argument copy FSM.
   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      idx_d   = idx_q;
      from_d  = from_q;
      to_d    = to_q;
      err_d   = 1'b0;

      if (writeEn && !busy_q && level_ok_s && addr_ok(writeAddr)) begin
         if (SharedVec[writeAddr]) begin
            regs_d[0][writeAddr] = writeData;
         end else begin
            regs_d[level][writeAddr] = writeData;
         end
      end else begin
         err_d = 1'b0;
      end

      if (entryEn && busy_q) begin
         err_d = 1'b1;
      end else if (entryEn) begin
         if (level_ok_s && RaOk) begin
            if (SharedVec[RaIdx]) begin
               regs_d[0][RaIdx] = RaMagic;
            end else begin
               regs_d[level][RaIdx] = RaMagic;
            end
         end else begin
            err_d = 1'b0;
         end
         to_d   = level;
         from_d = entryFrom;
         if ((ArgNum > 0) && (entryFrom != level)) begin
            state_d = COPY;
            idx_d   = {IdxW{1'b0}};
         end else begin
            state_d = IDLE;
         end
      end else begin
         err_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            idx_d = idx_d;
         end
         COPY: begin
            // Skipped slots (shared, x0, out of range) still consume a cycle.
            if (copy_ok_s) begin
               regs_d[to_q][cp_addr_s] = regs_q[from_q][cp_addr_s];
            end else begin
               idx_d = idx_q;
            end
            if (idx_q == IdxLast) begin
               state_d = IDLE;
               idx_d   = {IdxW{1'b0}};
            end else begin
               idx_d   = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = {IdxW{1'b0}};
         end
      endcase

      busy_d = (state_d == COPY);
   end

   // State registers; reset abandons any copy in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q  <= '{default: {DataWidth{1'b0}}};
         state_q <= IDLE;
         idx_q   <= {IdxW{1'b0}};
         from_q  <= {LevelW{1'b0}};
         to_q    <= {LevelW{1'b0}};
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         from_q  <= from_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign busy     = busy_q;
   assign entryErr = err_q;

endmodule
